// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with 16-byte blocks over a 1 KiB address window.
// Hits are served combinationally; misses stall the CPU through BUSYWAIT while a block is fetched.
module instruction_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  PC,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [5:0]   MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);
    // state      | meaning
    // S_IDLE     | serve hits; a miss stalls and latches the miss address
    // S_MEM_READ | request the latched block until memory returns it
    localparam int TAG_BITS   = 6 - INDEX_BITS;
    localparam int NUM_BLOCKS = 1 << INDEX_BITS;

    typedef enum logic {S_IDLE, S_MEM_READ} state_t;

    state_t state, state_next;

    logic                  valid [NUM_BLOCKS];
    logic [TAG_BITS-1:0]   tags  [NUM_BLOCKS];
    logic [127:0]          data  [NUM_BLOCKS];

    logic [TAG_BITS-1:0]   pc_tag, miss_tag;
    logic [INDEX_BITS-1:0] pc_index, miss_index;
    logic [1:0]            pc_word;
    logic                  hit;
    logic                  refill_done;
    logic                  unused_pc;

    assign pc_tag    = PC[9:4+INDEX_BITS];
    assign pc_index  = PC[3+INDEX_BITS:4];
    assign pc_word   = PC[3:2];
    assign unused_pc = ^{PC[31:10], PC[1:0]};

    assign hit         = valid[pc_index] && (tags[pc_index] == pc_tag);
    // Reset wins over a refill that completes on the same edge.
    assign refill_done = !RESET && (state == S_MEM_READ) && !MEM_BUSYWAIT;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            miss_tag   <= '0;
            miss_index <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                valid[i] <= 1'b0;
            end
        end else begin
            state <= state_next;
            if (state == S_IDLE && !hit) begin
                miss_tag   <= pc_tag;
                miss_index <= pc_index;
            end
            if (refill_done) begin
                valid[miss_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (refill_done) begin
            data[miss_index] <= MEM_READDATA;
            tags[miss_index] <= miss_tag;
        end
    end

    always_comb begin
        state_next  = state;
        INSTRUCTION = 32'h0;
        BUSYWAIT    = 1'b0;
        MEM_READ    = 1'b0;
        MEM_ADDRESS = 6'h0;
        if (RESET) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hit) begin
                        INSTRUCTION = data[pc_index][{pc_word, 5'd0} +: 32];
                    end else begin
                        BUSYWAIT   = 1'b1;
                        state_next = S_MEM_READ;
                    end
                end
                S_MEM_READ: begin
                    BUSYWAIT    = 1'b1;
                    MEM_READ    = 1'b1;
                    MEM_ADDRESS = {miss_tag, miss_index};
                    if (!MEM_BUSYWAIT) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end
endmodule
